// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port memory between the fetch
// port and the debug/loader port, with range checking, flush discard and a stall timeout.
module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  output logic                  if_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [31:0]           dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [31:0]           dbg_rdata,
  output logic                  dbg_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_WAIT  = 2'd1,
    ST_DBG_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_dbg_q, last_dbg_d;
  logic                  discard_q, discard_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  if_err_q, if_err_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
  logic                  dbg_rvalid_q, dbg_rvalid_d;
  logic                  dbg_err_q, dbg_err_d;
  logic [DATA_W-1:0]     dbg_rdata_q, dbg_rdata_d;

  logic if_cand;
  logic if_addr_bad;
  logic dbg_addr_bad;
  logic tmo_hit;

  // Misaligned or beyond the memory depth.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
  endfunction

  assign if_cand      = if_req & ~if_flush;
  assign if_addr_bad  = addr_bad(if_addr);
  assign dbg_addr_bad = addr_bad(dbg_addr);
  assign tmo_hit      = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TMO_LAST));

  // Round-robin grant, only from IDLE with the clock enabled.
  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst && clk_en && (state_q == ST_IDLE)) begin
      if (if_cand && dbg_req) begin
        if_gnt  = last_dbg_q;
        dbg_gnt = ~last_dbg_q;
      end else begin
        if_gnt  = if_cand;
        dbg_gnt = dbg_req;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_dbg_d   = last_dbg_q;
    discard_d    = discard_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rvalid_d  = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = '0;
    dbg_rvalid_d = 1'b0;
    dbg_err_d    = 1'b0;
    dbg_rdata_d  = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        discard_d = 1'b0;
        if (if_gnt) begin
          last_dbg_d = 1'b0;
          if (if_addr_bad) begin
            if_rvalid_d = 1'b1;
            if_err_d    = 1'b1;
          end else begin
            state_d     = ST_IF_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr[ADDR_WIDTH+1:2];
            mem_wdata_d = '0;
          end
        end else if (dbg_gnt) begin
          last_dbg_d = 1'b1;
          if (dbg_addr_bad) begin
            dbg_rvalid_d = 1'b1;
            dbg_err_d    = 1'b1;
          end else begin
            state_d     = ST_DBG_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr[ADDR_WIDTH+1:2];
            mem_wdata_d = dbg_wdata;
          end
        end
      end

      ST_IF_WAIT: begin
        if (if_flush) discard_d = 1'b1;
        if (mem_ready || tmo_hit) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          discard_d = 1'b0;
          // A flush seen now or earlier in this access swallows the response.
          if (!discard_q && !if_flush) begin
            if_rvalid_d = 1'b1;
            if_err_d    = ~mem_ready;
            if_rdata_d  = mem_ready ? mem_rdata : '0;
          end
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DBG_WAIT: begin
        if (mem_ready || tmo_hit) begin
          state_d      = ST_IDLE;
          mem_req_d    = 1'b0;
          cnt_d        = '0;
          dbg_rvalid_d = 1'b1;
          dbg_err_d    = ~mem_ready;
          dbg_rdata_d  = (mem_ready && !mem_we_q) ? mem_rdata : '0;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register; everything holds while clk_en is low, stretching rvalid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_dbg_q   <= 1'b1;
      discard_q    <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      dbg_rdata_q  <= '0;
    end else if (clk_en) begin
      state_q      <= state_d;
      last_dbg_q   <= last_dbg_d;
      discard_q    <= discard_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_err_q    <= dbg_err_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // A flush in the response cycle still kills the fetch strobe.
  assign if_rvalid  = if_rvalid_q & ~if_flush;
  assign if_err     = if_err_q;
  assign if_rdata   = if_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_err    = dbg_err_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: table of single transactions against a
// variable-latency memory model, plus hand sequences for arbitration, timeout, flush, clk_en and reset.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic        if_req, if_flush, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_req, mem_we, mem_ready, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  int mem_delay = 0;
  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_WIDTH(10), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  // Memory model: raises mem_ready mem_delay cycles after mem_req is first seen.
  initial begin
    int wcnt;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem_ready = 1'b0;
    mem_rdata = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && !mem_ready) begin
        if (wcnt == mem_delay) begin
          mem_ready = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          mem_rdata = mem_we ? 32'h0 : mem[mem_addr];
        end else begin
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wcnt = 0;
      end
    end
  end

  typedef struct {
    logic        dbg;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [9:0]  exp_maddr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    clk_en = 1'b1;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    mem_delay = 0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset ctrl", 32'({mem_req, mem_we, busy, if_rvalid, dbg_rvalid, if_err, dbg_err, if_gnt, dbg_gnt}), 32'h0);
    chk("reset data", if_rdata | dbg_rdata | mem_wdata | 32'(mem_addr), 32'h0);
    rst = 1'b0;
  endtask

  task automatic do_txn(input vec_t v, input string nm);
    int   n, lat;
    logic got, saw_req, other;
    tick();
    mem_delay = v.delay;
    if (v.dbg) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    n = 0;
    while (!(v.dbg ? dbg_gnt : if_gnt) && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " gnt"}, 32'(v.dbg ? dbg_gnt : if_gnt), 32'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    got = 1'b0; saw_req = 1'b0; other = 1'b0; lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      tick();
      if (mem_req && !saw_req) begin
        saw_req = 1'b1;
        chk({nm, " mem_addr"}, 32'(mem_addr), 32'(v.exp_maddr));
        chk({nm, " mem_we"}, 32'(mem_we), 32'(v.dbg & v.we));
      end
      if (v.dbg ? if_rvalid : dbg_rvalid) other = 1'b1;
      if (v.dbg ? dbg_rvalid : if_rvalid) begin
        got = 1'b1;
        lat = k;
        chk({nm, " rdata"}, v.dbg ? dbg_rdata : if_rdata, v.exp_rdata);
        chk({nm, " err"}, 32'(v.dbg ? dbg_err : if_err), 32'(v.exp_err));
      end
    end
    chk({nm, " latency"}, 32'(lat), v.exp_err ? 32'd1 : 32'(v.delay + 2));
    chk({nm, " mem access"}, 32'(saw_req), 32'(!v.exp_err));
    chk({nm, " other port quiet"}, 32'(other), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   gcnt, both, cnt, lat;
    logic g [4];
    logic seen;

    //            dbg   we    addr           wdata          dly err   rdata          maddr
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         2, 1'b0, 32'hA500_0004, 10'h004};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1, 1'b0, 32'h0,         10'h002};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 10'h002};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         3, 1'b0, 32'hDEAD_BEEF, 10'h002};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_1002, 32'h0,         0, 1'b1, 32'h0,         10'h000};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_4000, 32'h0,         0, 1'b1, 32'h0,         10'h000};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         1, 1'b0, 32'hA500_03FF, 10'h3FF};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0011, 32'h1234_5678, 0, 1'b1, 32'h0,         10'h000};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1, 1'b0, 32'hA500_0004, 10'h004};
    vecs[9] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         0, 1'b1, 32'h0,         10'h000};

    idle_inputs();
    rst = 1'b1;
    do_reset();

    // Both requesters held from reset: IF first, then strict alternation.
    tick();
    mem_delay = 0;
    if_req = 1'b1; if_addr = 32'h0;
    dbg_req = 1'b1; dbg_addr = 32'h4;
    gcnt = 0; both = 0;
    for (int k = 0; k < 20 && gcnt < 4; k++) begin
      #1;
      if (if_gnt && dbg_gnt) both++;
      else if (if_gnt || dbg_gnt) begin
        g[gcnt] = dbg_gnt;
        gcnt++;
      end
      @(negedge clk);
    end
    chk("rr grant count", 32'(gcnt), 32'd4);
    chk("rr never both", 32'(both), 32'd0);
    chk("rr order", 32'({g[0], g[1], g[2], g[3]}), 32'b0101);
    tick();
    if_req = 1'b0; dbg_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    do_reset();

    for (int i = 0; i < 10; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Memory never answers: mem_req held exactly 4 cycles, then error response.
    tick();
    mem_delay = 99;
    if_req = 1'b1; if_addr = 32'h20;
    #1;
    chk("tmo gnt", 32'(if_gnt), 32'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    cnt = 0; lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (mem_req) cnt++;
      if (if_rvalid && lat == 0) begin
        lat = k;
        chk("tmo err", 32'(if_err), 32'd1);
        chk("tmo rdata", if_rdata, 32'h0);
      end
    end
    chk("tmo mem_req cycles", 32'(cnt), 32'd4);
    chk("tmo latency", 32'(lat), 32'd5);
    chk("tmo idle", 32'(busy), 32'd0);
    mem_delay = 0;

    // Flush during IF_WAIT discards that response.
    tick();
    mem_delay = 3;
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk("flush gnt", 32'(if_gnt), 32'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    tick();
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (if_rvalid) seen = 1'b1;
    end
    chk("flush no rvalid", 32'(seen), 32'd0);
    chk("flush idle", 32'(busy), 32'd0);
    do_txn(vecs[0], "after flush");

    // Flush coinciding with the response strobe masks it.
    tick();
    mem_delay = 0;
    if_req = 1'b1; if_addr = 32'h10;
    @(posedge clk);
    #1;
    if_req = 1'b0;
    tick();
    tick();
    if_flush = 1'b1;
    #1;
    chk("flush same cycle", 32'(if_rvalid), 32'd0);
    if_flush = 1'b0;
    #1;
    chk("strobe without flush", 32'(if_rvalid), 32'd1);

    // Flush blocks the fetch grant.
    tick();
    if_flush = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk("flush blocks gnt a", 32'(if_gnt), 32'd0);
    tick();
    chk("flush blocks gnt b", 32'(if_gnt | busy), 32'd0);
    if_flush = 1'b0;
    #1;
    chk("gnt after flush", 32'(if_gnt), 32'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    // clk_en low stretches the response and blocks grants.
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    tick();
    tick();
    chk("clken rvalid", 32'(dbg_rvalid), 32'd1);
    clk_en = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("clken hold %0d", k), 32'({dbg_rvalid, if_gnt}), 32'b10);
    end
    chk("clken rdata", dbg_rdata, 32'hA500_0004);
    if_req = 1'b0;
    clk_en = 1'b1;
    tick();
    chk("clken release", 32'(dbg_rvalid), 32'd0);

    // Reset in the middle of a debug access.
    tick();
    mem_delay = 99;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    #1;
    chk("rst gnt", 32'(dbg_gnt), 32'd1);
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    tick();
    tick();
    chk("rst pre", 32'({mem_req, busy}), 32'b11);
    rst = 1'b1;
    tick();
    chk("rst mid", 32'({mem_req, busy, dbg_rvalid}), 32'b000);
    rst = 1'b0;
    mem_delay = 0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (dbg_rvalid || mem_req || busy) seen = 1'b1;
    end
    chk("rst quiet", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
